// File: rtl/bit_serial_adder.sv
// Bit-serial adder: adds two WIDTH-bit unsigned operands plus a carry-in,
// one full-adder slice per clock. Accepts a request in IDLE, shifts through
// WIDTH RUN cycles, then holds the result in DONE until the consumer takes it.
module bit_serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  // Counter must be able to hold WIDTH itself so it never wraps inside a run.
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_r, state_nxt_s;
  logic [WIDTH-1:0] a_r, a_nxt_s;
  logic [WIDTH-1:0] b_r, b_nxt_s;
  logic [WIDTH-1:0] sum_r, sum_nxt_s;
  logic             carry_r, carry_nxt_s;
  logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
  logic             in_ready_r, out_valid_r, busy_r;

  // Sum bit of a single full-adder slice.
  function automatic logic fa_sum(input logic x, input logic y, input logic z);
    return x ^ y ^ z;
  endfunction

  // Carry bit of a single full-adder slice (majority of the three inputs).
  function automatic logic fa_carry(input logic x, input logic y, input logic z);
    return (x & y) | (x & z) | (y & z);
  endfunction

  // Next-state and datapath update: capture in IDLE, one slice per RUN cycle, hold in DONE.
  always_comb begin
    state_nxt_s = state_r;
    a_nxt_s     = a_r;
    b_nxt_s     = b_r;
    sum_nxt_s   = sum_r;
    carry_nxt_s = carry_r;
    cnt_nxt_s   = cnt_r;
    case (state_r)
      IDLE: begin
        if (in_valid) begin
          a_nxt_s     = a;
          b_nxt_s     = b;
          carry_nxt_s = cin;
          cnt_nxt_s   = {CNT_W{1'b0}};
          sum_nxt_s   = {WIDTH{1'b0}};
          state_nxt_s = RUN;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RUN: begin
        // Sum bits enter at the MSB and move right, so after WIDTH slices
        // bit 0 of the result sits at bit 0 of the register.
        sum_nxt_s            = sum_r >> 1'b1;
        sum_nxt_s[WIDTH-1]   = fa_sum(a_r[0], b_r[0], carry_r);
        carry_nxt_s          = fa_carry(a_r[0], b_r[0], carry_r);
        a_nxt_s              = a_r >> 1'b1;
        b_nxt_s              = b_r >> 1'b1;
        cnt_nxt_s            = cnt_r + CNT_W'(1'b1);
        if (cnt_r == LAST_CNT) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = RUN;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = DONE;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State, datapath and registered handshake/status outputs; reset wins over any handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      a_r         <= {WIDTH{1'b0}};
      b_r         <= {WIDTH{1'b0}};
      sum_r       <= {WIDTH{1'b0}};
      carry_r     <= 1'b0;
      cnt_r       <= {CNT_W{1'b0}};
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      a_r         <= a_nxt_s;
      b_r         <= b_nxt_s;
      sum_r       <= sum_nxt_s;
      carry_r     <= carry_nxt_s;
      cnt_r       <= cnt_nxt_s;
      in_ready_r  <= (state_nxt_s == IDLE);
      out_valid_r <= (state_nxt_s == DONE);
      busy_r      <= (state_nxt_s != IDLE);
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign busy      = busy_r;
  assign sum       = sum_r;
  assign cout      = carry_r;

endmodule
